// File: rtl/reset_pkg.sv
// Shared types for the reset request controller.
// FSM state encoding and reset-cause bit positions.
package reset_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    RELEASE = 2'd2
  } rst_state_t;

  localparam int unsigned CAUSE_W   = 4;
  localparam int unsigned CAUSE_POR = 0;
  localparam int unsigned CAUSE_SW  = 1;
  localparam int unsigned CAUSE_WDT = 2;
  localparam int unsigned CAUSE_DBG = 3;

endpackage

// File: rtl/rst_hold_cnt.sv
// Clearable saturating up-counter with terminal-count flag.
// o_tc is high while the count equals MAX-1.
module rst_hold_cnt #(
  parameter int unsigned MAX = 16
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_clr,
  output logic o_tc
);

  localparam int unsigned W = $clog2(MAX + 1);

  logic [W-1:0] r_cnt;

  // Count up from zero, saturate at MAX so it never wraps.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (r_cnt != W'(MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == W'(MAX - 1));

endmodule

// File: rtl/reset_ctrl.sv
// Reset request controller: merged, stretched, sequenced reset.
// Optional RELEASE timeout enabled by RESET_CTRL_TIMEOUT_EN.
module reset_ctrl
  import reset_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_sw_req,
  input  logic               i_wdt_req,
  input  logic               i_dbg_req,
  input  logic               i_rst_done,
  input  logic               i_cause_clr,
  output logic               o_sys_rstn,
  output logic               o_busy,
  output logic [CAUSE_W-1:0] o_cause,
  output logic               o_timeout
);

  rst_state_t         r_state;
  logic               r_sys_rstn;
  logic               r_busy;
  logic [CAUSE_W-1:0] r_cause;
  logic [CAUSE_W-1:0] w_set;
  logic               w_req;
  logic               w_hold_clr;
  logic               w_hold_tc;
  logic               w_to_tc;

  assign w_req = i_sw_req | i_wdt_req | i_dbg_req;

  always_comb begin
    w_set            = '0;
    w_set[CAUSE_SW]  = i_sw_req;
    w_set[CAUSE_WDT] = i_wdt_req;
    w_set[CAUSE_DBG] = i_dbg_req;
  end

  // Hold count runs only in ASSERT; any request restarts it.
  assign w_hold_clr = (r_state != ASSERT) | w_req;

  rst_hold_cnt #(
    .MAX (HOLD_CYCLES)
  ) u_hold (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_clr  (w_hold_clr),
    .o_tc   (w_hold_tc)
  );

`ifdef RESET_CTRL_TIMEOUT_EN
  logic w_to_clr;
  logic r_timeout;

  assign w_to_clr = (r_state != RELEASE);

  rst_hold_cnt #(
    .MAX (TIMEOUT_CYCLES)
  ) u_wait (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_clr  (w_to_clr),
    .o_tc   (w_to_tc)
  );

  assign o_timeout = r_timeout;
`else
  logic w_unused_to;

  assign w_to_tc     = 1'b0;
  assign w_unused_to = |TIMEOUT_CYCLES;
  assign o_timeout   = 1'b0;
`endif

  // Sequencer FSM with registered reset and busy outputs.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state    <= ASSERT;
      r_sys_rstn <= 1'b0;
      r_busy     <= 1'b1;
`ifdef RESET_CTRL_TIMEOUT_EN
      r_timeout  <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_req) begin
            r_state    <= ASSERT;
            r_sys_rstn <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        ASSERT: begin
          if (!w_req && w_hold_tc) begin
            r_state    <= RELEASE;
            r_sys_rstn <= 1'b1;
          end
        end
        RELEASE: begin
          if (w_req) begin
            r_state    <= ASSERT;
            r_sys_rstn <= 1'b0;
          end else if (i_rst_done) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
          end else if (w_to_tc) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
`ifdef RESET_CTRL_TIMEOUT_EN
            r_timeout  <= 1'b1;
`endif
          end
        end
        default: begin
          r_state    <= ASSERT;
          r_sys_rstn <= 1'b0;
          r_busy     <= 1'b1;
        end
      endcase
    end
  end

  // Sticky cause bits; a same-cycle set wins over clear.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_cause <= CAUSE_W'(1) << CAUSE_POR;
    end else begin
      r_cause <= (i_cause_clr ? '0 : r_cause) | w_set;
    end
  end

  assign o_sys_rstn = r_sys_rstn;
  assign o_busy     = r_busy;
  assign o_cause    = r_cause;

endmodule

// File: tb/tb_reset_ctrl.sv
// Self-checking bench for reset_ctrl against a countdown model.
// Honours RESET_CTRL_TIMEOUT_EN when defined at compile time.
module tb_reset_ctrl;

  localparam int HOLD = 4;
  localparam int TO   = 8;

  logic       clk   = 1'b0;
  logic       rstn  = 1'b0;
  logic       sw    = 1'b0;
  logic       wdt   = 1'b0;
  logic       dbg   = 1'b0;
  logic       done  = 1'b0;
  logic       clr   = 1'b0;
  logic       sys_rstn;
  logic       busy;
  logic [3:0] cause;
  logic       tmo;

  int n_chk  = 0;
  int n_pass = 0;

  int      hold_left;
  int      wait_cnt;
  bit      waiting;
  bit      m_to;
  bit [3:0] m_cause;

  reset_ctrl #(
    .HOLD_CYCLES    (HOLD),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_sw_req    (sw),
    .i_wdt_req   (wdt),
    .i_dbg_req   (dbg),
    .i_rst_done  (done),
    .i_cause_clr (clr),
    .o_sys_rstn  (sys_rstn),
    .o_busy      (busy),
    .o_cause     (cause),
    .o_timeout   (tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  tag, obs, exp, $time);
  endtask

  // Model: reset is low while hold_left > 0; a request
  // reloads the full hold; then we wait for done.
  task automatic model_reset();
    hold_left = HOLD;
    waiting   = 1'b0;
    wait_cnt  = 0;
    m_cause   = 4'b0001;
    m_to      = 1'b0;
  endtask

  task automatic model_edge();
    bit req;
    req = sw | wdt | dbg;
    m_cause = (clr ? 4'b0000 : m_cause)
            | {dbg, wdt, sw, 1'b0};
    if (req) begin
      hold_left = HOLD;
      waiting   = 1'b0;
    end else if (hold_left > 0) begin
      hold_left--;
      if (hold_left == 0) begin
        waiting  = 1'b1;
        wait_cnt = 0;
      end
    end else if (waiting) begin
      if (done) begin
        waiting = 1'b0;
      end else begin
        wait_cnt++;
`ifdef RESET_CTRL_TIMEOUT_EN
        if (wait_cnt >= TO) begin
          waiting = 1'b0;
          m_to    = 1'b1;
        end
`endif
      end
    end
  endtask

  task automatic check_all();
    chk("sys_rstn", 32'(sys_rstn), 32'(hold_left == 0));
    chk("busy", 32'(busy),
        32'((hold_left > 0) || waiting));
    chk("cause", 32'(cause), 32'(m_cause));
    chk("timeout", 32'(tmo), 32'(m_to));
  endtask

  // Called at a negedge: drive, clock, re-check.
  task automatic cyc(input bit s, input bit w,
                     input bit d, input bit dn,
                     input bit c);
    sw   = s;
    wdt  = w;
    dbg  = d;
    done = dn;
    clr  = c;
    @(posedge clk);
    if (rstn) model_edge();
    @(negedge clk);
    check_all();
  endtask

  // Called at a negedge: async reset pulse.
  task automatic do_reset();
    rstn = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    @(negedge clk);
    check_all();
    rstn = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all();
    rstn = 1'b1;

    // POR release, then idle with done high
    repeat (6) cyc(0, 0, 0, 1, 0);
    // SW pulse from idle
    cyc(1, 0, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0);
    // WDT pulse mid-hold restarts it
    cyc(0, 1, 0, 0, 0);
    repeat (5) cyc(0, 0, 0, 0, 0);
    // DBG while waiting for done
    cyc(0, 0, 1, 0, 0);
    repeat (5) cyc(0, 0, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 1, 0);
    // clear alone, then clear with SW
    cyc(0, 0, 0, 1, 1);
    cyc(1, 0, 0, 1, 1);
    repeat (6) cyc(0, 0, 0, 1, 0);
    // done stuck low long enough to time out
    cyc(0, 0, 1, 0, 1);
    repeat (16) cyc(0, 0, 0, 0, 0);
    // async reset mid-hold
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    do_reset();
    repeat (8) cyc(0, 0, 0, 1, 0);

    for (int p = 0; p < 20; p++) begin
      int mode;
      mode = $urandom_range(0, 2);
      if ($urandom_range(0, 3) == 0) do_reset();
      for (int i = 0; i < 120; i++) begin
        bit s, w, d, dn, c;
        s  = ($urandom_range(0, 15) == 0);
        w  = ($urandom_range(0, 23) == 0);
        d  = ($urandom_range(0, 23) == 0);
        c  = ($urandom_range(0, 19) == 0);
        dn = (mode == 0) ? 1'b1 :
             (mode == 1) ? 1'b0 :
             ($urandom_range(0, 5) == 0);
        cyc(s, w, d, dn, c);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
